lane_packer: RTL and testbench

//  Write-side counterpart of mux_2_1. mux_2_1 selects one DATA_WIDTH slice out of a

---
 rtl/lane_packer.sv | 118 +++++++++++
 tb/tb_lane_packer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_packer.sv
// +--------------------------------------------------------------------------+
// | lane_packer: packs DATA_WIDTH words into a NUM_LANES-wide lane bus.       |
// | Optional LANE_PACKER_MASK_EN adds an out_mask port.  Revision: 1.0        |
// +--------------------------------------------------------------------------+
`default_nettype none

module lane_packer #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_LANES  = 2,
    localparam int CNT_W      = $clog2(NUM_LANES) + 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [DATA_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            flush,
    output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [CNT_W-1:0]                out_count
`ifdef LANE_PACKER_MASK_EN
    ,
    output logic [NUM_LANES-1:0]            out_mask
`endif
);

    localparam int                PTR_W     = $clog2(NUM_LANES);
    localparam logic [PTR_W-1:0]  LAST_LANE = PTR_W'(NUM_LANES - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                            r_state;
    logic [NUM_LANES*DATA_WIDTH-1:0]   r_acc;
    logic [NUM_LANES*DATA_WIDTH-1:0]   r_out_data;
    logic [NUM_LANES*DATA_WIDTH-1:0]   w_next_acc;
    logic [PTR_W-1:0]                  r_ptr;
    logic [CNT_W-1:0]                  r_out_count;
    logic [CNT_W-1:0]                  w_fill;
    logic                              w_in_acc;
    logic                              w_flush;
    logic                              w_full;
    logic                              w_emit;

    assign in_ready  = (r_state == FILL) || out_ready;
    assign w_in_acc  = in_valid && in_ready;
    assign w_flush   = flush && in_ready;
    assign w_full    = w_in_acc && (r_ptr == LAST_LANE);
    // Lanes that would be filled after this cycle's accept.
    assign w_fill    = CNT_W'(r_ptr) + CNT_W'(w_in_acc);
    assign w_emit    = w_full || (w_flush && (w_fill != '0));

    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_count = r_out_count;

    always_comb begin
        w_next_acc = r_acc;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_in_acc && (r_ptr == PTR_W'(i))) begin
                w_next_acc[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
            end
        end
    end

    // Emitting while HOLD implies out_ready, so overwriting the held word is safe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= FILL;
            r_acc       <= '0;
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_count <= '0;
        end else if (w_emit) begin
            r_state     <= HOLD;
            r_out_data  <= w_next_acc;
            r_out_count <= w_fill;
            r_acc       <= '0;
            r_ptr       <= '0;
        end else begin
            r_acc <= w_next_acc;
            if (w_in_acc) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if ((r_state == HOLD) && out_ready) begin
                r_state <= FILL;
            end
        end
    end

`ifdef LANE_PACKER_MASK_EN
    logic [NUM_LANES-1:0] r_out_mask;
    logic [NUM_LANES-1:0] w_mask;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_mask[i] = (CNT_W'(i) < w_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_mask <= '0;
        end else if (w_emit) begin
            r_out_mask <= w_mask;
        end
    end

    assign out_mask = r_out_mask;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_packer.sv
// Bench for lane_packer: two instances (2 lanes and 4 lanes) share one stimulus
// stream and are compared every cycle against a list-based packing model.
`default_nettype none

module tb_lane_packer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       in_valid;
    logic       flush;
    logic       out_ready;
    logic [7:0] in_data;

    logic        rdy2, ov2;
    logic [15:0] od2;
    logic [1:0]  oc2;
    logic        rdy4, ov4;
    logic [31:0] od4;
    logic [2:0]  oc4;
`ifdef LANE_PACKER_MASK_EN
    logic [1:0]  om2;
    logic [3:0]  om4;
`endif

    lane_packer #(.DATA_WIDTH(8), .NUM_LANES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy2), .flush(flush), .out_data(od2), .out_valid(ov2),
        .out_ready(out_ready), .out_count(oc2)
`ifdef LANE_PACKER_MASK_EN
        , .out_mask(om2)
`endif
    );

    lane_packer #(.DATA_WIDTH(8), .NUM_LANES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy4), .flush(flush), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .out_count(oc4)
`ifdef LANE_PACKER_MASK_EN
        , .out_mask(om4)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input int d, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s lanes=%0d: got %h expected %h", name, (d == 0) ? 2 : 4, got, exp);
        end
    endtask

    // Model: a list of accepted words per instance; a word is emitted when
    // the list reaches the lane count, or on a qualified flush with a non-empty list.
    logic        m_valid [2];
    logic [31:0] m_data  [2];
    int          m_count [2];
    logic [7:0]  m_buf   [2][4];
    int          m_n     [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_data[d] = '0; m_count[d] = 0; m_n[d] = 0;
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                int  nl;
                logic rdy;
                nl = (d == 0) ? 2 : 4;
                if (!reset_n) begin
                    m_valid[d] = 1'b0; m_data[d] = '0; m_count[d] = 0; m_n[d] = 0;
                end else begin
                    rdy = !m_valid[d] || out_ready;
                    if (m_valid[d] && out_ready) m_valid[d] = 1'b0;
                    if (in_valid && rdy) begin
                        m_buf[d][m_n[d]] = in_data;
                        m_n[d]++;
                    end
                    if ((m_n[d] == nl) || (flush && rdy && m_n[d] > 0)) begin
                        m_data[d] = '0;
                        for (int k = 0; k < m_n[d]; k++)
                            m_data[d] = m_data[d] | (32'(m_buf[d][k]) << (8 * k));
                        m_count[d] = m_n[d];
                        m_valid[d] = 1'b1;
                        m_n[d]     = 0;
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("out_valid", d, 32'((d == 0) ? ov2 : ov4), 32'(m_valid[d]));
                check("in_ready", d, 32'((d == 0) ? rdy2 : rdy4),
                      32'(!m_valid[d] || out_ready));
                if (m_valid[d]) begin
                    check("out_data", d, (d == 0) ? 32'(od2) : od4, m_data[d]);
                    check("out_count", d, 32'((d == 0) ? 3'(oc2) : oc4), 32'(m_count[d]));
`ifdef LANE_PACKER_MASK_EN
                    check("out_mask", d, 32'((d == 0) ? 4'(om2) : om4),
                          (32'd1 << m_count[d]) - 32'd1);
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
        reset_n  = 1'b1;
    endtask

    task automatic send(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
    endtask

    logic [15:0] stream_exp [4];

    initial begin
        stream_exp = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};

        // Reset held with in_valid high: nothing captured.
        reset_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; flush = 1'b0; out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", 0, 32'(ov2), 32'd0);
        check("rst_out_data", 0, 32'(od2), 32'd0);
        check("rst_out_count", 0, 32'(oc2), 32'd0);
        check("rst_in_ready", 0, 32'(rdy2), 32'd1);
        check("rst_out_data", 1, od4, 32'd0);
        reset_n = 1'b1; in_valid = 1'b0;
        step();
        check("rst_nothing_captured", 0, 32'(ov2), 32'd0);

        // Basic pack.
        send(8'h0F); send(8'hF0);
        check("basic_valid", 0, 32'(ov2), 32'd1);
        check("basic_data", 0, 32'(od2), 32'h0000F00F);
        check("basic_count", 0, 32'(oc2), 32'd2);
        in_valid = 1'b0;
        step();
        check("basic_one_cycle", 0, 32'(ov2), 32'd0);

        // Backpressure, then same-cycle output and input accept.
        do_reset();
        out_ready = 1'b0;
        send(8'h0F); send(8'hF0);
        in_valid = 1'b0;
        repeat (5) begin
            step();
            check("bp_in_ready", 0, 32'(rdy2), 32'd0);
            check("bp_data_stable", 0, 32'(od2), 32'h0000F00F);
        end
        out_ready = 1'b1;
        send(8'h55);
        check("bp_released", 0, 32'(ov2), 32'd0);
        send(8'h66);
        check("bp_next_word", 0, 32'(od2), 32'h00006655);
        check("bp_full4", 1, od4, 32'h6655F00F);
        in_valid = 1'b0;
        step();

        // Streaming with no input bubbles.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            #1;
            check("stream_in_ready", 0, 32'(rdy2), 32'd1);
            step();
            if (i % 2 == 0) check("stream_data", 0, 32'(od2), 32'(stream_exp[i/2-1]));
            if (i == 4) check("stream_data", 1, od4, 32'h04030201);
            if (i == 8) check("stream_data", 1, od4, 32'h08070605);
        end
        in_valid = 1'b0;
        step();

        // Flush with a same-cycle accept, then flush on an empty accumulator.
        do_reset();
        send(8'hAA);
        flush = 1'b1;
        send(8'hBB);
        check("flush_data", 1, od4, 32'h0000BBAA);
        check("flush_count", 1, 32'(oc4), 32'd2);
`ifdef LANE_PACKER_MASK_EN
        check("flush_mask", 1, 32'(om4), 32'h3);
`endif
        check("flush_full_data", 0, 32'(od2), 32'h0000BBAA);
        check("flush_full_count", 0, 32'(oc2), 32'd2);
        in_valid = 1'b0; flush = 1'b0;
        step();
        flush = 1'b1;
        step();
        check("flush_empty", 1, 32'(ov4), 32'd0);
        check("flush_empty", 0, 32'(ov2), 32'd0);
        flush = 1'b0;

        // Reset mid-assembly discards the partial word.
        do_reset();
        send(8'h11);
        reset_n = 1'b0; in_valid = 1'b0;
        step();
        reset_n = 1'b1;
        send(8'h22); send(8'h33);
        check("midrst_data", 0, 32'(od2), 32'h00003322);
        in_valid = 1'b0;
        step();

        // Randomized traffic.
        do_reset();
        repeat (3000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            flush     = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset_n   = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
